// File: rtl/rvga_imem_bridge_if.sv
// Memory-side valid/ready request bus and response channel for rvga_imem_bridge.
// master = bridge (issues requests), slave = instruction memory.
`timescale 1ns/1ps
interface rvga_imem_bridge_if #(
  parameter int unsigned WORD_W = 32
);
  logic              mem_req_v_o;
  logic              mem_req_ready_i;
  logic [WORD_W-1:0] mem_req_addr_o;
  logic              mem_resp_v_i;
  logic [WORD_W-1:0] mem_resp_data_i;

  modport master (
    output mem_req_v_o,
    output mem_req_addr_o,
    input  mem_req_ready_i,
    input  mem_resp_v_i,
    input  mem_resp_data_i
  );

  modport slave (
    input  mem_req_v_o,
    input  mem_req_addr_o,
    output mem_req_ready_i,
    output mem_resp_v_i,
    output mem_resp_data_i
  );
endinterface

// File: rtl/rvga_imem_bridge.sv
// Fetch-address tracker turning core address changes into single valid/ready memory requests.
// Optional sequential prefetch buffer enabled by defining RVGA_IMEM_PREFETCH_EN.
`timescale 1ns/1ps
module rvga_imem_bridge #(
  parameter int unsigned WORD_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WORD_W-1:0]   imem_addr_i,
  output logic [WORD_W-1:0]   imem_data_o,
  output logic                imem_resp_v_o,
  rvga_imem_bridge_if.master  mem
);

  localparam int unsigned TAG_W = WORD_W - 2;

`ifdef RVGA_IMEM_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, PF_REQ, PF_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
`endif

  state_t            state;
  logic              req_v;
  logic [TAG_W-1:0]  req_tag;
  logic              buf_v;
  logic [TAG_W-1:0]  buf_tag;
  logic [WORD_W-1:0] data_q;
  logic              resp_v;

  logic [TAG_W-1:0]  cur_tag;
  logic              fetch_needed;
  logic              unused_addr_bits;

  // Byte offset within the word never influences fetching.
  assign cur_tag          = imem_addr_i[WORD_W-1:2];
  assign unused_addr_bits = ^imem_addr_i[1:0];
  assign fetch_needed     = !buf_v || (cur_tag != buf_tag);

  assign mem.mem_req_v_o    = req_v;
  assign mem.mem_req_addr_o = {req_tag, 2'b00};
  assign imem_data_o        = data_q;
  assign imem_resp_v_o      = resp_v;

`ifdef RVGA_IMEM_PREFETCH_EN
  logic              pf_v;
  logic [TAG_W-1:0]  pf_tag;
  logic [WORD_W-1:0] pf_data;
  logic              pf_hit;
  logic              pf_keep;

  assign pf_hit  = pf_v && (cur_tag == pf_tag);
  // A prefetch is still worth keeping if the core sits on the buffered word or the prefetched one.
  assign pf_keep = (cur_tag == req_tag) || (buf_v && (cur_tag == buf_tag));
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      req_v   <= 1'b0;
      req_tag <= '0;
      buf_v   <= 1'b0;
      buf_tag <= '0;
      data_q  <= '0;
      resp_v  <= 1'b0;
`ifdef RVGA_IMEM_PREFETCH_EN
      pf_v    <= 1'b0;
      pf_tag  <= '0;
      pf_data <= '0;
`endif
    end else begin
      resp_v <= 1'b0;
      case (state)
        IDLE: begin
`ifdef RVGA_IMEM_PREFETCH_EN
          if (pf_hit) begin
            resp_v  <= 1'b1;
            data_q  <= pf_data;
            buf_tag <= pf_tag;
            buf_v   <= 1'b1;
            pf_v    <= 1'b0;
          end else if (fetch_needed) begin
            req_tag <= cur_tag;
            req_v   <= 1'b1;
            state   <= REQ;
          end else if (!pf_v) begin
            req_tag <= buf_tag + 1'b1;
            req_v   <= 1'b1;
            state   <= PF_REQ;
          end
`else
          if (fetch_needed) begin
            req_tag <= cur_tag;
            req_v   <= 1'b1;
            state   <= REQ;
          end
`endif
        end

        REQ: begin
          if (mem.mem_req_ready_i) begin
            req_v <= 1'b0;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (mem.mem_resp_v_i) begin
            // A response for an address the core has left is dropped; IDLE re-requests.
            if (cur_tag == req_tag) begin
              data_q  <= mem.mem_resp_data_i;
              resp_v  <= 1'b1;
              buf_tag <= req_tag;
              buf_v   <= 1'b1;
`ifdef RVGA_IMEM_PREFETCH_EN
              pf_v    <= 1'b0;
`endif
            end
            state <= IDLE;
          end
        end

`ifdef RVGA_IMEM_PREFETCH_EN
        PF_REQ: begin
          if (mem.mem_req_ready_i) begin
            req_v <= 1'b0;
            state <= PF_WAIT;
          end
        end

        PF_WAIT: begin
          if (mem.mem_resp_v_i) begin
            if (pf_keep) begin
              pf_tag  <= req_tag;
              pf_data <= mem.mem_resp_data_i;
              pf_v    <= 1'b1;
            end else begin
              pf_v    <= 1'b0;
            end
            state <= IDLE;
          end
        end
`endif

        default: begin
          req_v <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvga_imem_bridge.sv
// Directed bench for rvga_imem_bridge with a rule-based per-cycle output monitor.
// Prefetch scenarios run when RVGA_IMEM_PREFETCH_EN is defined; base scenarios otherwise.
`timescale 1ns/1ps
module tb_rvga_imem_bridge;

  localparam int unsigned WORD_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [WORD_W-1:0] imem_addr_i;
  logic [WORD_W-1:0] imem_data_o;
  logic              imem_resp_v_o;

  rvga_imem_bridge_if #(.WORD_W(WORD_W)) mem_if ();

  rvga_imem_bridge #(.WORD_W(WORD_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_addr_i   (imem_addr_i),
    .imem_data_o   (imem_data_o),
    .imem_resp_v_o (imem_resp_v_o),
    .mem           (mem_if)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Memory image: word 0 holds a NOP, every other word a tag derived from its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w == 32'h0) ? 32'h0000_0013 : (w ^ 32'h5A5A_0003);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Memory responder: answers each accepted request in the following cycle.
  logic        mute = 1'b0;
  int          inj_req = 0;
  logic [31:0] inj_data = 32'h0;

  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    int          inj_done;
    inj_done = 0;
    mem_if.mem_resp_v_i    = 1'b0;
    mem_if.mem_resp_data_i = 32'h0;
    forever begin
      @(negedge clk_i);
      acc      = mem_if.mem_req_v_o && mem_if.mem_req_ready_i;
      acc_addr = mem_if.mem_req_addr_o;
      @(posedge clk_i);
      #2;
      if (inj_req != inj_done) begin
        inj_done++;
        mem_if.mem_resp_v_i    = 1'b1;
        mem_if.mem_resp_data_i = inj_data;
      end else if (acc && !mute) begin
        mem_if.mem_resp_v_i    = 1'b1;
        mem_if.mem_resp_data_i = mem_word(acc_addr);
      end else begin
        mem_if.mem_resp_v_i    = 1'b0;
      end
    end
  end

  // Rule monitor: reset values, request stability, pulse data, data hold, one pulse per word.
  initial begin
    logic        r;
    logic        prev_stall;
    logic [31:0] prev_req_addr;
    logic [31:0] prev_addr;
    logic [31:0] last_data;
    logic        have_pulse;
    logic        moved;
    prev_stall = 1'b0; prev_req_addr = '0; prev_addr = '0;
    last_data = '0; have_pulse = 1'b0; moved = 1'b0;
    forever begin
      @(posedge clk_i);
      r = rst_i;
      @(negedge clk_i);
      if (!r) begin
        check("mon_rst_req_v", {31'b0, mem_if.mem_req_v_o}, 32'h0);
        check("mon_rst_resp_v", {31'b0, imem_resp_v_o}, 32'h0);
        check("mon_rst_data", imem_data_o, 32'h0);
        last_data  = '0;
        have_pulse = 1'b0;
        moved      = 1'b0;
      end else begin
        if (imem_addr_i[31:2] != prev_addr[31:2]) moved = 1'b1;
        if (prev_stall) begin
          check("mon_req_hold_v", {31'b0, mem_if.mem_req_v_o}, 32'h1);
          check("mon_req_hold_addr", mem_if.mem_req_addr_o, prev_req_addr);
        end
        if (mem_if.mem_req_v_o)
          check("mon_req_align", {30'b0, mem_if.mem_req_addr_o[1:0]}, 32'h0);
        if (imem_resp_v_o) begin
          check("mon_pulse_data", imem_data_o, mem_word(imem_addr_i));
          check("mon_pulse_new_word", {31'b0, (moved || !have_pulse)}, 32'h1);
          last_data  = imem_data_o;
          have_pulse = 1'b1;
          moved      = 1'b0;
        end else begin
          check("mon_data_hold", imem_data_o, last_data);
        end
      end
      prev_stall    = r && mem_if.mem_req_v_o && !mem_if.mem_req_ready_i;
      prev_req_addr = mem_if.mem_req_addr_o;
      prev_addr     = imem_addr_i;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i                  = 1'b0;
    imem_addr_i            = 32'h0;
    mem_if.mem_req_ready_i = 1'b1;

`ifndef RVGA_IMEM_PREFETCH_EN
    // 1: reset, fetch of 0x0 with single-cycle memory
    repeat (3) tick();
    check("t1_rst_req_v", {31'b0, mem_if.mem_req_v_o}, 32'h0);
    rst_i = 1'b1;
    tick();
    check("t1_req_v", {31'b0, mem_if.mem_req_v_o}, 32'h1);
    check("t1_req_addr", mem_if.mem_req_addr_o, 32'h0);
    check("t1_no_early_pulse", {31'b0, imem_resp_v_o}, 32'h0);
    tick();
    check("t1_wait_req_v", {31'b0, mem_if.mem_req_v_o}, 32'h0);
    tick();
    check("t1_pulse", {31'b0, imem_resp_v_o}, 32'h1);
    check("t1_data", imem_data_o, 32'h0000_0013);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_hold_pulse", {31'b0, imem_resp_v_o}, 32'h0);
      check("t1_hold_req", {31'b0, mem_if.mem_req_v_o}, 32'h0);
    end

    // 2: request stalled by ready while the core moves to 0x8
    rst_i = 1'b0;
    mem_if.mem_req_ready_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    check("t2_req_v", {31'b0, mem_if.mem_req_v_o}, 32'h1);
    check("t2_req_addr", mem_if.mem_req_addr_o, 32'h0);
    imem_addr_i = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_stall_v", {31'b0, mem_if.mem_req_v_o}, 32'h1);
      check("t2_stall_addr", mem_if.mem_req_addr_o, 32'h0);
    end
    mem_if.mem_req_ready_i = 1'b1;
    tick();
    check("t2_accept_v", {31'b0, mem_if.mem_req_v_o}, 32'h0);
    tick();
    check("t2_drop_pulse", {31'b0, imem_resp_v_o}, 32'h0);
    tick();
    check("t2_req8_v", {31'b0, mem_if.mem_req_v_o}, 32'h1);
    check("t2_req8_addr", mem_if.mem_req_addr_o, 32'h8);
    tick();
    tick();
    check("t2_pulse", {31'b0, imem_resp_v_o}, 32'h1);
    check("t2_data", imem_data_o, 32'h5A5A_000B);
    tick();

    // 3: byte offset changes within a word trigger nothing
    imem_addr_i = 32'h10;
    tick();
    check("t3_req_addr", mem_if.mem_req_addr_o, 32'h10);
    tick();
    tick();
    check("t3_pulse", {31'b0, imem_resp_v_o}, 32'h1);
    check("t3_data", imem_data_o, 32'h5A5A_0013);
    tick();
    imem_addr_i = 32'h13;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_no_req", {31'b0, mem_if.mem_req_v_o}, 32'h0);
      check("t3_no_pulse", {31'b0, imem_resp_v_o}, 32'h0);
    end

    // 4: reset while waiting; the orphaned response arrives after release
    imem_addr_i = 32'h20;
    tick();
    check("t4_req_addr", mem_if.mem_req_addr_o, 32'h20);
    mute = 1'b1;
    tick();
    check("t4_wait_v", {31'b0, mem_if.mem_req_v_o}, 32'h0);
    rst_i = 1'b0;
    tick();
    check("t4_rst_pulse", {31'b0, imem_resp_v_o}, 32'h0);
    rst_i = 1'b1;
    mem_if.mem_req_ready_i = 1'b0;
    tick();
    check("t4_rereq_v", {31'b0, mem_if.mem_req_v_o}, 32'h1);
    inj_data = 32'hDEAD_BEEF;
    tick();
    inj_req++;
    tick();
    check("t4_stale_pulse", {31'b0, imem_resp_v_o}, 32'h0);
    check("t4_stale_req_v", {31'b0, mem_if.mem_req_v_o}, 32'h1);
    check("t4_stale_req_addr", mem_if.mem_req_addr_o, 32'h20);
    mute = 1'b0;
    mem_if.mem_req_ready_i = 1'b1;
    tick();
    tick();
    check("t4_pulse", {31'b0, imem_resp_v_o}, 32'h1);
    check("t4_data", imem_data_o, 32'h5A5A_0023);
    repeat (2) tick();
`else
    // 5: demand fetch, automatic prefetch, prefetch hit, redirect mid-prefetch
    imem_addr_i = 32'h100;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    check("t5_req_addr", mem_if.mem_req_addr_o, 32'h100);
    tick();
    tick();
    check("t5_pulse", {31'b0, imem_resp_v_o}, 32'h1);
    check("t5_data", imem_data_o, 32'h5A5A_0103);
    tick();
    check("t5_pf_req_v", {31'b0, mem_if.mem_req_v_o}, 32'h1);
    check("t5_pf_req_addr", mem_if.mem_req_addr_o, 32'h104);
    tick();
    tick();
    check("t5_pf_no_pulse", {31'b0, imem_resp_v_o}, 32'h0);
    imem_addr_i = 32'h104;
    tick();
    check("t5_hit_pulse", {31'b0, imem_resp_v_o}, 32'h1);
    check("t5_hit_data", imem_data_o, 32'h5A5A_0107);
    tick();
    check("t5_pf2_req_addr", mem_if.mem_req_addr_o, 32'h108);
    imem_addr_i = 32'h200;
    tick();
    tick();
    check("t5_drop_pulse", {31'b0, imem_resp_v_o}, 32'h0);
    tick();
    check("t5_req200_v", {31'b0, mem_if.mem_req_v_o}, 32'h1);
    check("t5_req200_addr", mem_if.mem_req_addr_o, 32'h200);
    tick();
    tick();
    check("t5_pulse200", {31'b0, imem_resp_v_o}, 32'h1);
    check("t5_data200", imem_data_o, 32'h5A5A_0203);
    tick();

    // 6: prefetch address wraps past the top of the address space
    rst_i = 1'b0;
    imem_addr_i = 32'hFFFF_FFFC;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    check("t6_req_addr", mem_if.mem_req_addr_o, 32'hFFFF_FFFC);
    tick();
    tick();
    check("t6_pulse", {31'b0, imem_resp_v_o}, 32'h1);
    check("t6_data", imem_data_o, 32'hA5A5_FFFF);
    tick();
    check("t6_wrap_req_v", {31'b0, mem_if.mem_req_v_o}, 32'h1);
    check("t6_wrap_req_addr", mem_if.mem_req_addr_o, 32'h0);
    repeat (3) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
